// File: rtl/sys_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sys_cmd_pkg
// Brief   : Shared constants for the UART register/ALU command protocol:
//           command header bytes, request encoding, frame lengths and the
//           master state encoding.
// Revision: 1.0 - initial release
// ============================================================================
package sys_cmd_pkg;

  // Frame header bytes recognised by the system controller
  localparam logic [7:0] c_HDR_WRITE   = 8'hAA;
  localparam logic [7:0] c_HDR_READ    = 8'hBB;
  localparam logic [7:0] c_HDR_ALU_OPS = 8'hCC;
  localparam logic [7:0] c_HDR_ALU     = 8'hDD;

  // req_cmd encoding
  localparam logic [1:0] c_CMD_WRITE   = 2'd0;
  localparam logic [1:0] c_CMD_READ    = 2'd1;
  localparam logic [1:0] c_CMD_ALU_OPS = 2'd2;
  localparam logic [1:0] c_CMD_ALU     = 2'd3;

  // Frame lengths in bytes, header included
  localparam logic [2:0] c_LEN_WRITE   = 3'd3;
  localparam logic [2:0] c_LEN_READ    = 3'd2;
  localparam logic [2:0] c_LEN_ALU_OPS = 3'd4;
  localparam logic [2:0] c_LEN_ALU     = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD     = 2'd1,
    ST_SEND     = 2'd2,
    ST_WAIT_RSP = 2'd3
  } state_e;

  function automatic logic [2:0] frame_len(input logic [1:0] cmd);
    logic [2:0] len;
    case (cmd)
      c_CMD_WRITE:   len = c_LEN_WRITE;
      c_CMD_READ:    len = c_LEN_READ;
      c_CMD_ALU_OPS: len = c_LEN_ALU_OPS;
      default:       len = c_LEN_ALU;
    endcase
    return len;
  endfunction

  function automatic logic [7:0] cmd_header(input logic [1:0] cmd);
    logic [7:0] hdr;
    case (cmd)
      c_CMD_WRITE:   hdr = c_HDR_WRITE;
      c_CMD_READ:    hdr = c_HDR_READ;
      c_CMD_ALU_OPS: hdr = c_HDR_ALU_OPS;
      default:       hdr = c_HDR_ALU;
    endcase
    return hdr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sys_cmd_rsp_timer.sv
`default_nettype none
// ============================================================================
// Module  : sys_cmd_rsp_timer
// Brief   : 16-bit response wait timer. Cleared on entry to the wait state,
//           counts while enabled, flags expiry on the cycle the count reaches
//           Timeout_cycles-1 so the owner reacts Timeout_cycles after entry.
// Revision: 1.0 - initial release
// ============================================================================
module sys_cmd_rsp_timer #(
  parameter int Timeout_cycles = 50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic count_i,
  output logic expire_o
);

  localparam logic [15:0] c_LIMIT = 16'(Timeout_cycles - 1);

  logic [15:0] count_q;

  // Count wait cycles; clear has priority so each wait starts from zero
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (count_i && !expire_o) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign expire_o = count_i && (count_q == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/sys_cmd_master.sv
`default_nettype none
// ============================================================================
// Module  : sys_cmd_master
// Brief   : Host-side command initiator. Accepts one request, serialises it
//           into an AA/BB/CC/DD frame towards a UART transmitter, then
//           captures the single response byte from the UART receiver.
//           Optional response timeout enabled by macro SYS_CMD_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module sys_cmd_master
  import sys_cmd_pkg::*;
#(
  parameter int Data_width     = 8,
  parameter int Address_width  = 4,
  parameter int Timeout_cycles = 50000
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_cmd,
  input  logic [Address_width-1:0] req_addr,
  input  logic [Data_width-1:0]    req_data,
  input  logic [Data_width-1:0]    req_opB,
  input  logic [3:0]               req_fun,
  output logic [Data_width-1:0]    TX_p_data,
  output logic                     TX_d_valid,
  input  logic                     TX_busy,
  input  logic [Data_width-1:0]    RX_p_data,
  input  logic                     RX_d_valid,
  output logic [Data_width-1:0]    rsp_data,
  output logic                     rsp_valid,
  output logic                     rsp_timeout,
  output logic                     busy
);

  state_e                   state_q;
  logic [1:0]               cmd_q;
  logic [Address_width-1:0] addr_q;
  logic [Data_width-1:0]    data_q;
  logic [Data_width-1:0]    opb_q;
  logic [3:0]               fun_q;
  logic [2:0]               len_q;
  logic [1:0]               idx_q;
  logic [Data_width-1:0]    tx_data_q;
  logic                     tx_valid_q;
  logic [Data_width-1:0]    rsp_data_q;
  logic                     rsp_valid_q;
  logic                     req_ready_q;
  logic                     busy_q;

  logic w_accept;
  logic w_tx_accept;
  logic w_last_byte;
  logic w_expire;

  // Byte at position idx of the frame described by the captured request
  function automatic logic [Data_width-1:0] frame_byte(
    input logic [1:0]               cmd,
    input logic [1:0]               idx,
    input logic [Address_width-1:0] addr,
    input logic [Data_width-1:0]    data,
    input logic [Data_width-1:0]    opb,
    input logic [3:0]               fun
  );
    logic [Data_width-1:0] hdr;
    logic [Data_width-1:0] addr_x;
    logic [Data_width-1:0] fun_x;
    logic [Data_width-1:0] byte_v;
    hdr    = Data_width'(cmd_header(cmd));
    addr_x = Data_width'(addr);
    fun_x  = Data_width'(fun);
    byte_v = '0;
    case (cmd)
      c_CMD_WRITE: begin
        case (idx)
          2'd0:    byte_v = hdr;
          2'd1:    byte_v = addr_x;
          default: byte_v = data;
        endcase
      end
      c_CMD_READ: begin
        byte_v = (idx == 2'd0) ? hdr : addr_x;
      end
      c_CMD_ALU_OPS: begin
        case (idx)
          2'd0:    byte_v = hdr;
          2'd1:    byte_v = data;
          2'd2:    byte_v = opb;
          default: byte_v = fun_x;
        endcase
      end
      default: begin
        byte_v = (idx == 2'd0) ? hdr : fun_x;
      end
    endcase
    return byte_v;
  endfunction

  assign w_accept    = req_valid && req_ready_q;
  assign w_tx_accept = tx_valid_q && !TX_busy;
  assign w_last_byte = ({1'b0, idx_q} == (len_q - 3'd1));

`ifdef SYS_CMD_TIMEOUT_EN
  logic rsp_timeout_q;
  logic w_timer_clear;
  logic w_timer_count;

  assign w_timer_clear = (state_q == ST_SEND) && w_tx_accept && w_last_byte;
  assign w_timer_count = (state_q == ST_WAIT_RSP);

  sys_cmd_rsp_timer #(
    .Timeout_cycles(Timeout_cycles)
  ) u_rsp_timer (
    .clk_i    (CLK),
    .rst_ni   (RST),
    .clear_i  (w_timer_clear),
    .count_i  (w_timer_count),
    .expire_o (w_expire)
  );

  assign rsp_timeout = rsp_timeout_q;
`else
  logic w_unused_timeout_cfg;

  // Without the timer the wait state only ever leaves on a response
  assign w_expire             = 1'b0;
  assign w_unused_timeout_cfg = (Timeout_cycles == 0);
  assign rsp_timeout          = 1'b0;
`endif

  // Request / frame / response sequencer with all outputs registered
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      opb_q       <= '0;
      fun_q       <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SYS_CMD_TIMEOUT_EN
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
`ifdef SYS_CMD_TIMEOUT_EN
      rsp_timeout_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (w_accept) begin
            // Request fields are sampled here and never again
            cmd_q       <= req_cmd;
            addr_q      <= req_addr;
            data_q      <= req_data;
            opb_q       <= req_opB;
            fun_q       <= req_fun;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= ST_LOAD;
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        ST_LOAD: begin
          len_q      <= frame_len(cmd_q);
          idx_q      <= 2'd0;
          tx_data_q  <= frame_byte(cmd_q, 2'd0, addr_q, data_q, opb_q, fun_q);
          tx_valid_q <= 1'b1;
          state_q    <= ST_SEND;
        end
        ST_SEND: begin
          if (w_tx_accept) begin
            if (w_last_byte) begin
              tx_valid_q <= 1'b0;
              state_q    <= ST_WAIT_RSP;
            end else begin
              idx_q     <= idx_q + 2'd1;
              tx_data_q <= frame_byte(cmd_q, idx_q + 2'd1, addr_q, data_q, opb_q, fun_q);
            end
          end
        end
        ST_WAIT_RSP: begin
          // A response arriving on the expiry cycle takes priority
          if (RX_d_valid) begin
            rsp_data_q  <= RX_p_data;
            rsp_valid_q <= 1'b1;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end else if (w_expire) begin
`ifdef SYS_CMD_TIMEOUT_EN
            rsp_timeout_q <= 1'b1;
`endif
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign busy       = busy_q;
  assign TX_p_data  = tx_data_q;
  assign TX_d_valid = tx_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_valid  = rsp_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_sys_cmd_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_sys_cmd_master
// Brief   : Self-checking bench for sys_cmd_master. A frame/response model
//           built from the protocol rules is compared against the DUT every
//           cycle; directed literals pin the model. Timeout scenarios run
//           when SYS_CMD_TIMEOUT_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sys_cmd_master;

  localparam int c_DW = 8;
  localparam int c_AW = 4;
  localparam int c_TO = 20;
`ifdef SYS_CMD_TIMEOUT_EN
  localparam bit c_TO_EN = 1'b1;
`else
  localparam bit c_TO_EN = 1'b0;
`endif

  logic            CLK = 1'b0;
  logic            RST = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [1:0]      req_cmd = '0;
  logic [c_AW-1:0] req_addr = '0;
  logic [c_DW-1:0] req_data = '0;
  logic [c_DW-1:0] req_opB = '0;
  logic [3:0]      req_fun = '0;
  logic [c_DW-1:0] TX_p_data;
  logic            TX_d_valid;
  logic            TX_busy = 1'b0;
  logic [c_DW-1:0] RX_p_data = '0;
  logic            RX_d_valid = 1'b0;
  logic [c_DW-1:0] rsp_data;
  logic            rsp_valid;
  logic            rsp_timeout;
  logic            busy;

  sys_cmd_master #(
    .Data_width(c_DW), .Address_width(c_AW), .Timeout_cycles(c_TO)
  ) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_addr(req_addr), .req_data(req_data), .req_opB(req_opB), .req_fun(req_fun),
    .TX_p_data(TX_p_data), .TX_d_valid(TX_d_valid), .TX_busy(TX_busy),
    .RX_p_data(RX_p_data), .RX_d_valid(RX_d_valid),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_timeout(rsp_timeout),
    .busy(busy)
  );

  initial forever #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=no-event required=event (cycle %0d)", name, cyc);
  endtask

  // ---------------- model state ----------------
  logic [7:0] exp_tx[$];
  logic [7:0] obs_tx[$];
  int         acc_cyc[$];
  bit         m_pend_wait = 0;
  bit         m_waiting   = 0;
  bit         m_exp_rsp   = 0;
  bit         m_exp_to    = 0;
  logic [7:0] m_rsp_data  = '0;
  int         m_k = 0;
  int         m_entry_cyc = 0;
  bit         prev_valid = 0;
  bit         prev_busy  = 0;
  logic [7:0] prev_data  = '0;
  int         busy_mode  = 0;

  // Expected frame straight from the protocol's frame table
  task automatic push_frame(input logic [1:0] cmd, input logic [3:0] addr,
                            input logic [7:0] data, input logic [7:0] opb,
                            input logic [3:0] fun);
    case (cmd)
      2'd0: begin exp_tx.push_back(8'hAA); exp_tx.push_back({4'h0, addr}); exp_tx.push_back(data); end
      2'd1: begin exp_tx.push_back(8'hBB); exp_tx.push_back({4'h0, addr}); end
      2'd2: begin exp_tx.push_back(8'hCC); exp_tx.push_back(data); exp_tx.push_back(opb);
                  exp_tx.push_back({4'h0, fun}); end
      default: begin exp_tx.push_back(8'hDD); exp_tx.push_back({4'h0, fun}); end
    endcase
  endtask

  // Per-cycle compare against the model, sampled on the falling edge
  initial forever begin
    @(negedge CLK);
    if (!RST) begin
      prev_valid = 0;
    end else begin
      check("rsp_valid", rsp_valid, m_exp_rsp);
      check("rsp_timeout", rsp_timeout, m_exp_to);
      check("rsp_data", rsp_data, m_rsp_data);
      m_exp_rsp = 0;
      m_exp_to  = 0;
      if (m_pend_wait) begin
        m_waiting   = 1;
        m_k         = 0;
        m_entry_cyc = cyc;
        m_pend_wait = 0;
      end
      if (m_waiting) begin
        if (RX_d_valid) begin
          m_exp_rsp  = 1;
          m_rsp_data = RX_p_data;
          m_waiting  = 0;
        end else if (c_TO_EN && (m_k == c_TO - 1)) begin
          m_exp_to  = 1;
          m_waiting = 0;
        end else begin
          m_k++;
        end
      end
      if (prev_valid && prev_busy) begin
        check("tx_hold_valid", TX_d_valid, 1);
        check("tx_hold_data", TX_p_data, prev_data);
      end
      if (TX_d_valid) begin
        if (exp_tx.size() == 0) begin
          fail("tx_unexpected_byte");
        end else begin
          check("tx_byte", TX_p_data, exp_tx[0]);
          if (!TX_busy) begin
            void'(exp_tx.pop_front());
            obs_tx.push_back(TX_p_data);
            acc_cyc.push_back(cyc);
            if (exp_tx.size() == 0) m_pend_wait = 1;
          end
        end
      end
      prev_valid = TX_d_valid;
      prev_busy  = TX_busy;
      prev_data  = TX_p_data;
    end
  end

  // TX_busy source: idle, or busy three cycles out of every four
  initial forever begin
    @(posedge CLK);
    #2;
    TX_busy = (busy_mode != 0) ? ((cyc % 4) != 3) : 1'b0;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tasks ----------------
  task automatic issue(input logic [1:0] cmd, input logic [3:0] addr, input logic [7:0] data,
                       input logic [7:0] opb, input logic [3:0] fun, output int n);
    int t;
    t = 0;
    obs_tx.delete();
    acc_cyc.delete();
    @(posedge CLK); #2;
    while (!req_ready && t < 200) begin
      @(posedge CLK); #2;
      t++;
    end
    check("req_ready_before_issue", req_ready, 1);
    req_valid = 1; req_cmd = cmd; req_addr = addr; req_data = data; req_opB = opb; req_fun = fun;
    n = cyc;
    push_frame(cmd, addr, data, opb, fun);
    @(posedge CLK); #2;
    // Scramble the fields to show they were captured at acceptance
    req_valid = 0; req_cmd = ~cmd; req_addr = ~addr; req_data = ~data; req_opB = ~opb; req_fun = ~fun;
    check("busy_in_load", busy, 1);
    check("req_ready_in_load", req_ready, 0);
  endtask

  task automatic wait_waiting();
    int t;
    t = 0;
    while (!m_waiting && t < 200) begin
      @(posedge CLK); #2;
      t++;
    end
    if (!m_waiting) fail("wait_rsp_entry");
  endtask

  task automatic respond(input logic [7:0] val);
    wait_waiting();
    check("busy_in_wait", busy, 1);
    RX_p_data = val; RX_d_valid = 1;
    @(posedge CLK); #2;
    RX_d_valid = 0; RX_p_data = 8'h5A;
    check("rsp_valid_direct", rsp_valid, 1);
    check("rsp_data_direct", rsp_data, val);
    check("req_ready_after_rsp", req_ready, 1);
    check("busy_after_rsp", busy, 0);
    // A late strobe in IDLE must be discarded
    RX_p_data = 8'h99; RX_d_valid = 1;
    @(posedge CLK); #2;
    RX_d_valid = 0;
    check("rsp_valid_late_strobe", rsp_valid, 0);
  endtask

  task automatic check_obs(input string name, input int n, input logic [7:0] b0,
                           input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] ex[4];
    ex[0] = b0; ex[1] = b1; ex[2] = b2; ex[3] = b3;
    check({name, "_len"}, obs_tx.size(), n);
    for (int i = 0; i < n && i < obs_tx.size(); i++) check(name, obs_tx[i], ex[i]);
  endtask

  task automatic check_reset_values();
    check("rst_req_ready", req_ready, 0);
    check("rst_tx_data", TX_p_data, 0);
    check("rst_tx_valid", TX_d_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_timeout", rsp_timeout, 0);
    check("rst_busy", busy, 0);
  endtask

  task automatic clear_model();
    exp_tx.delete();
    m_pend_wait = 0; m_waiting = 0; m_exp_rsp = 0; m_exp_to = 0;
    m_rsp_data = '0; prev_valid = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int t;
    int e;
    repeat (3) @(posedge CLK);
    #2;
    check_reset_values();
    RST = 1;
    @(posedge CLK); #2;
    check("req_ready_first_cycle", req_ready, 1);
    check("busy_first_cycle", busy, 0);

    // Write: AA,05,3C back to back, response 00
    issue(2'd0, 4'h5, 8'h3C, 8'h00, 4'h0, n);
    respond(8'h00);
    check_obs("write_bytes", 3, 8'hAA, 8'h05, 8'h3C, 8'h00);
    if (acc_cyc.size() == 3) begin
      check("write_byte0_cycle", acc_cyc[0] - n, 2);
      check("write_byte1_cycle", acc_cyc[1] - n, 3);
      check("write_byte2_cycle", acc_cyc[2] - n, 4);
    end else fail("write_accept_count");

    // Read with a slow transmitter: BB,0F, response A5
    busy_mode = 1;
    issue(2'd1, 4'hF, 8'h00, 8'h00, 4'h0, n);
    respond(8'hA5);
    busy_mode = 0;
    check_obs("read_bytes", 2, 8'hBB, 8'h0F, 8'h00, 8'h00);
    if (acc_cyc.size() == 2) check("read_byte_spacing", acc_cyc[1] - acc_cyc[0], 4);
    else fail("read_accept_count");
    check("read_rsp_literal", rsp_data, 8'hA5);

    // ALU with operands: CC,07,03,01 with a stray RX strobe mid-frame
    issue(2'd2, 4'h0, 8'h07, 8'h03, 4'h1, n);
    @(posedge CLK); #2;
    RX_p_data = 8'hEE; RX_d_valid = 1;
    @(posedge CLK); #2;
    RX_d_valid = 0;
    respond(8'h04);
    check_obs("alu_ops_bytes", 4, 8'hCC, 8'h07, 8'h03, 8'h01);
    if (acc_cyc.size() == 4) check("alu_ops_last_cycle", acc_cyc[3] - n, 5);
    else fail("alu_ops_accept_count");
    check("alu_ops_rsp_literal", rsp_data, 8'h04);

    // ALU without operands: DD,0A
`ifdef SYS_CMD_TIMEOUT_EN
    issue(2'd3, 4'h0, 8'h00, 8'h00, 4'hA, n);
    wait_waiting();
    e = m_entry_cyc;
    t = 0;
    while (!rsp_timeout && t < 100) begin
      @(posedge CLK); #2;
      t++;
    end
    if (!rsp_timeout) fail("timeout_pulse");
    else begin
      check("timeout_delay", cyc - e, c_TO);
      check("timeout_req_ready", req_ready, 1);
      check("timeout_rsp_data_kept", rsp_data, 8'h04);
    end
    check_obs("alu_bytes", 2, 8'hDD, 8'h0A, 8'h00, 8'h00);
    // Strobe on the expiry cycle: response wins
    issue(2'd3, 4'h0, 8'h00, 8'h00, 4'hA, n);
    wait_waiting();
    e = m_entry_cyc;
    while (cyc < e + c_TO - 1) begin
      @(posedge CLK); #2;
    end
    RX_p_data = 8'h3E; RX_d_valid = 1;
    @(posedge CLK); #2;
    RX_d_valid = 0;
    check("expiry_race_rsp_valid", rsp_valid, 1);
    check("expiry_race_rsp_timeout", rsp_timeout, 0);
    check("expiry_race_rsp_data", rsp_data, 8'h3E);
`else
    issue(2'd3, 4'h0, 8'h00, 8'h00, 4'hA, n);
    respond(8'h0B);
    check_obs("alu_bytes", 2, 8'hDD, 8'h0A, 8'h00, 8'h00);
`endif

    // Reset in the middle of a cmd2 frame, then a clean cmd3 frame
    issue(2'd2, 4'h0, 8'h11, 8'h22, 4'h5, n);
    t = 0;
    while (obs_tx.size() < 2 && t < 100) begin
      @(posedge CLK); #2;
      t++;
    end
    if (obs_tx.size() < 2) fail("midframe_progress");
    RST = 0;
    #1;
    check_reset_values();
    clear_model();
    @(posedge CLK); #2;
    check_reset_values();
    RST = 1;
    @(posedge CLK); #2;
    check("req_ready_after_rerelease", req_ready, 1);
    issue(2'd3, 4'h0, 8'h00, 8'h00, 4'h3, n);
    respond(8'h77);
    check_obs("post_reset_bytes", 2, 8'hDD, 8'h03, 8'h00, 8'h00);

    repeat (3) @(posedge CLK);
    #2;
    check("tx_queue_drained", exp_tx.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
